writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_pkg.sv | 12 +
 rtl/writeback_queue_if.sv | 35 +++
 rtl/writeback_queue_fifo.sv | 43 ++++
 rtl/writeback_queue.sv | 106 ++++++++++
 4 files changed

// File: rtl/writeback_queue_pkg.sv
// Shared types and widths for the writeback queue: register-file entry record
// and default queue depth.
package writeback_queue_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int WBQ_DEPTH  = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_queue_if.sv
// Bundle of the two producer handshakes, the register-file write port,
// the pending-write probe and the occupancy flags.
interface writeback_queue_if import writeback_queue_pkg::*; ();
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0]     mem_data;
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0]     alu_data;
  logic                  wb_stall;
  logic                  regWrite;
  logic [REG_ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0]     writeData;
  logic [REG_ADDR_W-1:0] lookupReg;
  logic                  lookupHit;
  logic [DATA_W-1:0]     lookupData;
  logic                  queue_full;
  logic                  queue_empty;

  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
           wb_stall, lookupReg,
    input  mem_ready, alu_ready, regWrite, writeReg, writeData,
           lookupHit, lookupData, queue_full, queue_empty
  );

  modport slave (
    input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
           wb_stall, lookupReg,
    output mem_ready, alu_ready, regWrite, writeReg, writeData,
           lookupHit, lookupData, queue_full, queue_empty
  );
endinterface

// File: rtl/writeback_queue_fifo.sv
// Entry storage and pointers for the writeback queue. Storage is exposed so the
// parent can search pending writes; it is deliberately not cleared on reset.
module wb_fifo import writeback_queue_pkg::*; #(
  parameter  int DEPTH = WBQ_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  wb_entry_t      push_entry,
  input  logic           pop,
  output wb_entry_t      head,
  output wb_entry_t      entries [DEPTH],
  output logic [PW-1:0]  rd_ptr,
  output logic [CW-1:0]  count
);
  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;
endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: merges load and ALU results (loads win) into a FIFO that
// drains one entry per cycle into a registered register-file write port.
module writeback_queue import writeback_queue_pkg::*; #(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  writeback_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t             head;
  wb_entry_t             entries [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  space;
  logic                  mem_fire, alu_fire, push, pop;
  wb_entry_t             push_entry;
  logic                  wb_valid_q;
  logic [REG_ADDR_W-1:0] wb_reg_q;
  logic [DATA_W-1:0]     wb_data_q;
  logic                  q_hit;
  logic [DATA_W-1:0]     q_data;
  logic [PW-1:0]         idx;

  // Readiness looks only at the registered count: no credit for a same-cycle pop.
  assign space         = (count < DEPTH_C);
  assign bus.mem_ready = space;
  assign bus.alu_ready = space && !bus.mem_valid;
  assign mem_fire      = bus.mem_valid && space;
  assign alu_fire      = bus.alu_valid && space && !bus.mem_valid;

  always_comb begin
    push_entry = '{rd: bus.alu_reg, data: bus.alu_data};
    push       = alu_fire && (bus.alu_reg != '0);
    if (mem_fire) begin
      push_entry = '{rd: bus.mem_reg, data: bus.mem_data};
      push       = (bus.mem_reg != '0);
    end
  end

  assign pop = (count != '0) && !bus.wb_stall;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .entries    (entries),
    .rd_ptr     (rd_ptr),
    .count      (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= pop;
      if (pop) begin
        wb_reg_q  <= head.rd;
        wb_data_q <= head.data;
      end
    end
  end

  assign bus.regWrite  = wb_valid_q;
  assign bus.writeReg  = wb_reg_q;
  assign bus.writeData = wb_data_q;

  // Walk oldest to youngest so the last match is the youngest pending value.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (entries[idx].rd == bus.lookupReg)) begin
        q_hit  = 1'b1;
        q_data = entries[idx].data;
      end
    end
  end

  always_comb begin
    bus.lookupHit  = 1'b0;
    bus.lookupData = '0;
    if (bus.lookupReg != '0) begin
      if (q_hit) begin
        bus.lookupHit  = 1'b1;
        bus.lookupData = q_data;
      end else if (wb_valid_q && (wb_reg_q == bus.lookupReg)) begin
        bus.lookupHit  = 1'b1;
        bus.lookupData = wb_data_q;
      end
    end
  end

  assign bus.queue_full  = (count == DEPTH_C);
  assign bus.queue_empty = (count == '0);
endmodule
